switch_out_arbiter: RTL

- Per-output-port scheduler for the 4-port switch; one instance per output port.
- Samples all input ports every cycle and keeps packets whose one-hot target selects this port.
- Buffers them in per-input FIFOs and grants one packet per cycle, round-robin, onto the port's output channel (valid_out/source_out/target_out/data_out).
- The input side has no backpressure, so overflow is a counted drop, never a stall.

---
 rtl/packet_pkg.sv | 14 +
 rtl/switch_out_arbiter_if.sv | 27 ++
 rtl/switch_out_arbiter_fifo.sv | 44 ++++
 rtl/switch_out_arbiter.sv | 128 ++++++++++++
 4 files changed

// File: rtl/packet_pkg.sv
// Shared packet types and switch-wide constants for the 4-port switch.
package packet_pkg;

    localparam int NUM_PORTS  = 4;
    localparam int ADDR_WIDTH = 4;
    localparam int DATA_WIDTH = 8;

    typedef struct packed {
        logic [ADDR_WIDTH-1:0] source;
        logic [ADDR_WIDTH-1:0] target;
        logic [DATA_WIDTH-1:0] data;
    } pkt_t;

endpackage

// File: rtl/switch_out_arbiter_if.sv
// Packet bus between the switch inputs and one output-port scheduler.
interface switch_out_arbiter_if
    import packet_pkg::*;
#(
    parameter int NUM_PORTS = packet_pkg::NUM_PORTS
);
    logic [NUM_PORTS-1:0]                 valid_in;
    logic [NUM_PORTS-1:0][ADDR_WIDTH-1:0] source_in;
    logic [NUM_PORTS-1:0][ADDR_WIDTH-1:0] target_in;
    logic [NUM_PORTS-1:0][DATA_WIDTH-1:0] data_in;
    logic                                 valid_out;
    logic [ADDR_WIDTH-1:0]                source_out;
    logic [ADDR_WIDTH-1:0]                target_out;
    logic [DATA_WIDTH-1:0]                data_out;
    logic [NUM_PORTS-1:0]                 fifo_full;
    logic [NUM_PORTS-1:0]                 drop_pulse;

    modport master (
        output valid_in, source_in, target_in, data_in,
        input  valid_out, source_out, target_out, data_out, fifo_full, drop_pulse
    );

    modport slave (
        input  valid_in, source_in, target_in, data_in,
        output valid_out, source_out, target_out, data_out, fifo_full, drop_pulse
    );
endinterface

// File: rtl/switch_out_arbiter_fifo.sv
// Single-clock packet FIFO; pointers carry one extra wrap bit for full/empty.
module arb_fifo
    import packet_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic clk,
    input  logic rst_n,
    input  logic push,
    input  logic pop,
    input  pkt_t din,
    output pkt_t head,
    output logic full,
    output logic empty
);
    localparam int AW    = $clog2(DEPTH);
    localparam int PTR_W = AW + 1;

    pkt_t             mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr_reg;
    logic [PTR_W-1:0] rd_ptr_reg;

    // Storage is not reset: a flush only needs the pointers cleared.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr_reg[AW-1:0]] <= din;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
        end else begin
            if (push) wr_ptr_reg <= wr_ptr_reg + PTR_W'(1);
            if (pop)  rd_ptr_reg <= rd_ptr_reg + PTR_W'(1);
        end
    end

    assign head  = mem[rd_ptr_reg[AW-1:0]];
    assign empty = (wr_ptr_reg == rd_ptr_reg);
    assign full  = (wr_ptr_reg[AW] != rd_ptr_reg[AW]) &&
                   (wr_ptr_reg[AW-1:0] == rd_ptr_reg[AW-1:0]);
endmodule

// File: rtl/switch_out_arbiter.sv
// Per-output-port round-robin scheduler with per-input FIFOs and drop reporting.
// Optional SWITCH_ARB_STATS_EN adds saturating per-input drop/grant counters.
module switch_out_arbiter
    import packet_pkg::*;
#(
    parameter int NUM_PORTS  = packet_pkg::NUM_PORTS,
    parameter int PORT_ID    = 0,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 arb_en,
    switch_out_arbiter_if.slave  bus
`ifdef SWITCH_ARB_STATS_EN
    ,
    input  logic                         stats_clr,
    output logic [NUM_PORTS-1:0][15:0]   drop_cnt,
    output logic [NUM_PORTS-1:0][15:0]   grant_cnt
`endif
);
    localparam int IDX_W = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1;

    pkt_t                 pkt_in [NUM_PORTS];
    pkt_t                 head   [NUM_PORTS];
    logic [NUM_PORTS-1:0] push_req;
    logic [NUM_PORTS-1:0] push;
    logic [NUM_PORTS-1:0] pop;
    logic [NUM_PORTS-1:0] full;
    logic [NUM_PORTS-1:0] empty;
    logic [NUM_PORTS-1:0] drop_next;
    logic [NUM_PORTS-1:0] drop_reg;

    logic [IDX_W-1:0] last_grant_reg;
    logic [IDX_W-1:0] grant_idx;
    logic [IDX_W-1:0] cand;
    logic             grant_valid;
    logic             valid_out_reg;
    pkt_t             out_pkt_reg;

    genvar gi;
    generate
        for (gi = 0; gi < NUM_PORTS; gi++) begin : g_port
            assign pkt_in[gi]    = '{source: bus.source_in[gi],
                                     target: bus.target_in[gi],
                                     data:   bus.data_in[gi]};
            assign push_req[gi]  = bus.valid_in[gi] && bus.target_in[gi][PORT_ID];
            assign pop[gi]       = grant_valid && (grant_idx == IDX_W'(gi));
            // A full FIFO still accepts when it is popped on the same edge.
            assign push[gi]      = push_req[gi] && (!full[gi] || pop[gi]);
            assign drop_next[gi] = push_req[gi] && full[gi] && !pop[gi];

            arb_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
                .clk   (clk),
                .rst_n (rst_n),
                .push  (push[gi]),
                .pop   (pop[gi]),
                .din   (pkt_in[gi]),
                .head  (head[gi]),
                .full  (full[gi]),
                .empty (empty[gi])
            );
        end
    endgenerate

    // First non-empty FIFO at or after last_grant+1, wrapping.
    always_comb begin
        grant_valid = 1'b0;
        grant_idx   = '0;
        cand        = '0;
        for (int k = 0; k < NUM_PORTS; k++) begin
            cand = IDX_W'((int'(last_grant_reg) + 1 + k) % NUM_PORTS);
            if (arb_en && !grant_valid && !empty[cand]) begin
                grant_valid = 1'b1;
                grant_idx   = cand;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            last_grant_reg <= IDX_W'(NUM_PORTS - 1);
            valid_out_reg  <= 1'b0;
            out_pkt_reg    <= '0;
            drop_reg       <= '0;
        end else begin
            drop_reg      <= drop_next;
            valid_out_reg <= grant_valid;
            if (grant_valid) begin
                last_grant_reg <= grant_idx;
                out_pkt_reg    <= head[grant_idx];
            end
        end
    end

    assign bus.valid_out  = valid_out_reg;
    assign bus.source_out = out_pkt_reg.source;
    assign bus.target_out = out_pkt_reg.target;
    assign bus.data_out   = out_pkt_reg.data;
    assign bus.fifo_full  = full;
    assign bus.drop_pulse = drop_reg;

`ifdef SWITCH_ARB_STATS_EN
    generate
        for (gi = 0; gi < NUM_PORTS; gi++) begin : g_stats
            logic [15:0] drop_cnt_reg;
            logic [15:0] grant_cnt_reg;

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    drop_cnt_reg  <= '0;
                    grant_cnt_reg <= '0;
                end else if (stats_clr) begin
                    drop_cnt_reg  <= '0;
                    grant_cnt_reg <= '0;
                end else begin
                    if (drop_next[gi] && drop_cnt_reg != 16'hFFFF)
                        drop_cnt_reg <= drop_cnt_reg + 16'd1;
                    if (pop[gi] && grant_cnt_reg != 16'hFFFF)
                        grant_cnt_reg <= grant_cnt_reg + 16'd1;
                end
            end

            assign drop_cnt[gi]  = drop_cnt_reg;
            assign grant_cnt[gi] = grant_cnt_reg;
        end
    endgenerate
`endif
endmodule
